// File: rtl/picorv_tcm_loader_pkg.sv
// Shared types and constants for the picorv32 TCM loader.
// Holds the FSM encoding, default TCM sizes and the burst range check.
package picorv_tcm_loader_pkg;

  localparam int unsigned PicorvItcmRamSz = 32'd16384;
  localparam int unsigned PicorvDtcmRamSz = 32'd8192;

  localparam logic [3:0] WenWord = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrIssue,
    StWrAck,
    StRdIssue,
    StRdAck,
    StRdOut,
    StDone
  } state_e;

  // True when a burst of len words at byte offset addr runs past the end of a bytes-sized TCM.
  function automatic logic range_err(logic [31:0] addr, logic [31:0] len, int unsigned bytes);
    logic [33:0] end_b;
    end_b = {2'b00, addr} + {len, 2'b00};
    return end_b > 34'(bytes);
  endfunction

endpackage

// File: rtl/picorv_tcm_loader_if.sv
// External TCM access port of the picosoc subsystem.
// The loader drives the master side; the TCM answers on the slave side.
interface picorv_tcm_loader_if;
  logic        ram_cs;
  logic [31:0] ram_addr;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ready;

  modport master (
    output ram_cs, ram_addr, ram_wen, ram_wdata,
    input  ram_rdata, ready
  );

  modport slave (
    input  ram_cs, ram_addr, ram_wen, ram_wdata,
    output ram_rdata, ready
  );
endinterface

// File: rtl/picorv_tcm_loader_tmo.sv
// Loadable down-counter with an expiry flag for bounding handshake waits.
// Counting stops at zero; expired_o stays high until the next load.
module picorv_tcm_loader_tmo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/picorv_tcm_loader.sv
// Host-side burst loader for the picorv32 ITCM/DTCM external access ports.
// Streams words in or out one access at a time and holds the core in reset while busy.
module picorv_tcm_loader
  import picorv_tcm_loader_pkg::*;
#(
  parameter int unsigned ITCM_BYTES = PicorvItcmRamSz,
  parameter int unsigned DTCM_BYTES = PicorvDtcmRamSz,
  parameter int unsigned LEN_WTH    = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               resetn,

  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_sel_i,
  input  logic               cmd_write_i,
  input  logic [31:0]        cmd_addr_i,
  input  logic [LEN_WTH-1:0] cmd_len_i,

  input  logic               din_valid_i,
  input  logic [31:0]        din_data_i,
  output logic               din_ready_o,

  output logic               dout_valid_o,
  output logic [31:0]        dout_data_o,
  input  logic               dout_ready_i,

  picorv_tcm_loader_if.master ext_itcm,
  picorv_tcm_loader_if.master ext_dtcm,

  input  logic               cpu_hold_i,
  output logic               cpu_resetn_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_WTH-1:0] len_q, len_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               live_q;
  logic               cpu_resetn_q, cpu_resetn_d;

  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        cmd_accept;
  logic        cmd_bad_range;
  logic        last_word;
  logic        in_ack;
  logic        advance;
  logic        tmo_expired;
  logic        issue;
  logic        wr_issue;

  assign sel_ready     = sel_q ? ext_dtcm.ready : ext_itcm.ready;
  assign sel_rdata     = sel_q ? ext_dtcm.ram_rdata : ext_itcm.ram_rdata;
  assign cmd_accept    = (state_q == StIdle) && live_q && cmd_valid_i;
  assign cmd_bad_range = range_err(cmd_addr_i & 32'hFFFF_FFFC, 32'(cmd_len_i),
                                   cmd_sel_i ? DTCM_BYTES : ITCM_BYTES);
  assign last_word     = (len_q == LEN_WTH'(1));
  assign in_ack        = (state_q == StWrAck) || (state_q == StRdAck);
  assign advance       = ((state_q == StWrAck) && sel_ready) ||
                         ((state_q == StRdOut) && dout_ready_i);

  picorv_tcm_loader_tmo #(
    .Width (TmoW)
  ) u_tmo (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     ((state_q == StWrIssue) || (state_q == StRdIssue)),
    .load_val_i (TmoW'(TIMEOUT)),
    .en_i       (in_ack),
    .expired_o  (tmo_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          if (cmd_bad_range || (cmd_len_i == '0)) begin
            state_d = StDone;
          end else begin
            state_d = cmd_write_i ? StWrData : StRdIssue;
          end
        end
      end
      StWrData:  if (din_valid_i) state_d = StWrIssue;
      StWrIssue: state_d = StWrAck;
      StWrAck: begin
        if (sel_ready) begin
          state_d = last_word ? StDone : StWrData;
        end else if (tmo_expired) begin
          state_d = StDone;
        end
      end
      StRdIssue: state_d = StRdAck;
      StRdAck: begin
        if (sel_ready) begin
          state_d = StRdOut;
        end else if (tmo_expired) begin
          state_d = StDone;
        end
      end
      StRdOut: begin
        if (dout_ready_i) begin
          state_d = last_word ? StDone : StRdIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (cmd_accept) begin
      sel_d  = cmd_sel_i;
      addr_d = cmd_addr_i & 32'hFFFF_FFFC;
      len_d  = cmd_len_i;
      err_d  = cmd_bad_range;
    end
    if ((state_q == StWrData) && din_valid_i) begin
      wdata_d = din_data_i;
    end
    if ((state_q == StRdAck) && sel_ready) begin
      rdata_d = sel_rdata;
    end
    if (advance) begin
      addr_d = addr_q + 32'd4;
      len_d  = len_q - LEN_WTH'(1);
    end
    if (in_ack && !sel_ready && tmo_expired) begin
      err_d = 1'b1;
    end
    // Uses next state so the core drops into reset on the same edge the loader takes the TCMs.
    cpu_resetn_d = !((state_d != StIdle) || cpu_hold_i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      live_q       <= 1'b0;
      cpu_resetn_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      live_q       <= 1'b1;
      cpu_resetn_q <= cpu_resetn_d;
    end
  end

  always_comb begin
    issue    = (state_q == StWrIssue) || (state_q == StRdIssue);
    wr_issue = (state_q == StWrIssue);

    // live_q keeps cmd_ready_o at 0 during and just after reset.
    cmd_ready_o  = (state_q == StIdle) && live_q;
    din_ready_o  = (state_q == StWrData);
    dout_valid_o = (state_q == StRdOut);
    dout_data_o  = rdata_q;
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    err_o        = err_q;
    cpu_resetn_o = cpu_resetn_q;

    ext_itcm.ram_cs    = issue && !sel_q;
    ext_itcm.ram_wen   = (wr_issue && !sel_q) ? WenWord : 4'h0;
    ext_itcm.ram_addr  = addr_q;
    ext_itcm.ram_wdata = wdata_q;

    ext_dtcm.ram_cs    = issue && sel_q;
    ext_dtcm.ram_wen   = (wr_issue && sel_q) ? WenWord : 4'h0;
    ext_dtcm.ram_addr  = addr_q;
    ext_dtcm.ram_wdata = wdata_q;
  end

endmodule
